pipe_stage: RTL



---
 rtl/pipe_stage.sv | 101 ++++++++++
 1 files changed

// File: rtl/pipe_stage.sv
// Elastic stage: optional wrap/saturate increment, then LATENCY register stages; item visible LATENCY-1 edges after its accept edge.
// Backpressure ripples combinationally from next_ready through the load enables, so bubbles collapse and full throughput holds.
module pipe_stage #(
    parameter int          WIDTH     = 5,
    parameter int          LATENCY   = 1,
    parameter int unsigned INCREMENT = 1,
    parameter bit          SATURATE  = 1'b0,
    localparam int         OCC_W     = $clog2(LATENCY + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             prev_valid,
    output logic             this_ready,
    output logic             this_valid,
    input  logic             next_ready,
    input  logic [WIDTH-1:0] input_num,
    output logic [WIDTH-1:0] output_num,
    output logic [OCC_W-1:0] occupancy
);

    if (LATENCY < 1 || LATENCY > 16) begin : g_bad_latency
        $error("pipe_stage: LATENCY must be in 1..16");
    end
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("pipe_stage: WIDTH must be in 1..32");
    end
    if (64'(INCREMENT) >= (64'd1 << WIDTH)) begin : g_bad_increment
        $error("pipe_stage: INCREMENT must fit in WIDTH bits");
    end

    localparam logic [63:0]    INC64   = 64'(INCREMENT);
    localparam logic [WIDTH:0] INC_EXT = INC64[WIDTH:0];

    logic [LATENCY-1:0][WIDTH-1:0] s_q, s_d;
    logic [LATENCY-1:0]            v_q, v_d;
    logic [LATENCY-1:0]            ld;
    logic                          ld_acc;
    logic                          accept;
    logic [WIDTH:0]                sum;
    logic [WIDTH-1:0]              f_val;
    logic [OCC_W-1:0]              occ_cnt;

    // The carry bit of the WIDTH+1 sum is exactly the overflow indication.
    always_comb begin
        sum   = {1'b0, input_num} + INC_EXT;
        f_val = sum[WIDTH-1:0];
        if (SATURATE && sum[WIDTH]) begin
            f_val = '1;
        end
    end

    // A stage may load when it is empty or everything downstream of it moves.
    always_comb begin
        ld     = '0;
        ld_acc = next_ready;
        for (int i = LATENCY - 1; i >= 0; i--) begin
            ld_acc = ld_acc | ~v_q[i];
            ld[i]  = ld_acc;
        end
    end

    assign this_ready = ld[0] & ~reset;
    assign accept     = prev_valid & this_ready;

    always_comb begin
        s_d = s_q;
        v_d = v_q;
        if (ld[0]) begin
            s_d[0] = f_val;
            v_d[0] = accept;
        end
        for (int i = 1; i < LATENCY; i++) begin
            if (ld[i]) begin
                s_d[i] = s_q[i-1];
                v_d[i] = v_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_q <= '0;
            v_q <= '0;
        end else begin
            s_q <= s_d;
            v_q <= v_d;
        end
    end

    always_comb begin
        occ_cnt = '0;
        for (int i = 0; i < LATENCY; i++) begin
            occ_cnt = occ_cnt + OCC_W'(v_q[i]);
        end
    end

    assign this_valid = v_q[LATENCY-1];
    assign output_num = s_q[LATENCY-1];
    assign occupancy  = occ_cnt;

endmodule
